// File: rtl/u_rf_scoreboard_pkg.sv
// rtl/u_rf_scoreboard_pkg.sv - shared sizes, issue-slot struct and helpers for the RF scoreboard
package u_rf_scoreboard_pkg;

    // Global register-file geometry shared with the rest of the core.
    localparam int SUPER_SCALAR_NUM = 2;
    localparam int RF_DEPTH         = 32;
    localparam int RF_DEPTH_BIT     = 5;

    // Pending-write counter width and its saturation value.
    localparam int SB_CNT_W = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = {SB_CNT_W{1'b1}};

    // Stall performance counter width.
    localparam int PERF_W = 32;

    // One decoded instruction as seen by the scoreboard.
    typedef struct packed {
        logic                    vld;
        logic [RF_DEPTH_BIT-1:0] rs1_idx;
        logic                    rs1_use;
        logic [RF_DEPTH_BIT-1:0] rs2_idx;
        logic                    rs2_use;
        logic                    rd_wen;
        logic [RF_DEPTH_BIT-1:0] rd;
    } sb_slot_t;

    // Population count of two request bits, giving a value 0..2.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/u_rf_sb_cnt.sv
// rtl/u_rf_sb_cnt.sv - pending-write counter for one architectural register
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       clear the counter next cycle, ignoring this cycle's inc/dec
//   inc         number of issuing slots that write this register (0..2)
//   dec         number of writeback slots that complete this register (0..2)
//   eff         count after this cycle's writebacks (clamped at 0)
//   cnt_next    value the counter takes on the next clock edge
//   underflow   pulse: more writebacks than pending writes this cycle
module u_rf_sb_cnt
    import u_rf_scoreboard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [1:0]          inc,
    input  logic [1:0]          dec,
    output logic [SB_CNT_W-1:0] eff,
    output logic [SB_CNT_W-1:0] cnt_next,
    output logic                underflow
);

    logic [SB_CNT_W-1:0] cnt_q;
    logic [SB_CNT_W:0]   diff;
    logic [SB_CNT_W:0]   sum;
    logic                borrow;

    // One extra bit captures the borrow of cnt - dec.
    assign diff   = {1'b0, cnt_q} - {{(SB_CNT_W-1){1'b0}}, dec};
    assign borrow = diff[SB_CNT_W];
    assign eff    = borrow ? '0 : diff[SB_CNT_W-1:0];

    // Issue logic never lets the sum exceed SB_CNT_MAX; saturate anyway so a
    // protocol violation cannot wrap a busy register back to "ready".
    assign sum = {1'b0, eff} + {{(SB_CNT_W-1){1'b0}}, inc};

    always_comb begin
        cnt_next = '0;
        if (!flush) begin
            cnt_next = sum[SB_CNT_W] ? SB_CNT_MAX : sum[SB_CNT_W-1:0];
        end
    end

    // Writebacks in a flush cycle are discarded, so they cannot underflow.
    assign underflow = !flush && borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/u_rf_scoreboard.sv
// rtl/u_rf_scoreboard.sv - issue-side RAW/overflow hazard controller for the 2W/2R register file
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               pipeline flush; blocks issue and clears all pending state
//   idu_sb_*[i]         decoded instruction in in-order issue slot i
//   lsu_sb_*[j]         writeback slot j completing a register write
//   sb_idu_issue_ok[i]  slot i may issue this cycle (combinational)
//   sb_busy_any         some register has a pending write (registered)
//   sb_err              sticky writeback underflow error
//   sb_stall_cnt        cycles slot 0 was valid but blocked
module u_rf_scoreboard
    import u_rf_scoreboard_pkg::*;
(
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           flush,
    input  logic [SUPER_SCALAR_NUM-1:0]                    idu_sb_vld,
    input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0]  idu_sb_rs1_idx,
    input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0]  idu_sb_rs2_idx,
    input  logic [SUPER_SCALAR_NUM-1:0]                    idu_sb_rs1_use,
    input  logic [SUPER_SCALAR_NUM-1:0]                    idu_sb_rs2_use,
    input  logic [SUPER_SCALAR_NUM-1:0]                    idu_sb_rd_wen,
    input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0]  idu_sb_rd,
    input  logic [SUPER_SCALAR_NUM-1:0]                    lsu_sb_pipe_vld,
    input  logic [SUPER_SCALAR_NUM-1:0]                    lsu_sb_wen,
    input  logic [SUPER_SCALAR_NUM-1:0][RF_DEPTH_BIT-1:0]  lsu_sb_rd,
    output logic [SUPER_SCALAR_NUM-1:0]                    sb_idu_issue_ok,
    output logic                                           sb_busy_any,
    output logic                                           sb_err,
    output logic [PERF_W-1:0]                              sb_stall_cnt
);

    sb_slot_t            slot [SUPER_SCALAR_NUM];
    logic [SB_CNT_W-1:0] eff_arr      [RF_DEPTH];
    logic [SB_CNT_W-1:0] cnt_next_arr [RF_DEPTH];
    logic [RF_DEPTH-1:0] uf_vec;
    logic [RF_DEPTH-1:0] busy_vec;
    logic [SUPER_SCALAR_NUM-1:0] wb_hit;
    logic [SUPER_SCALAR_NUM-1:0] fire;
    logic [SUPER_SCALAR_NUM-1:0] issue_ok;

    // Bundle the per-slot ports into one struct per slot.
    always_comb begin
        for (int i = 0; i < SUPER_SCALAR_NUM; i++) begin
            slot[i].vld     = idu_sb_vld[i];
            slot[i].rs1_idx = idu_sb_rs1_idx[i];
            slot[i].rs1_use = idu_sb_rs1_use[i];
            slot[i].rs2_idx = idu_sb_rs2_idx[i];
            slot[i].rs2_use = idu_sb_rs2_use[i];
            slot[i].rd_wen  = idu_sb_rd_wen[i];
            slot[i].rd      = idu_sb_rd[i];
        end
    end

    assign wb_hit = lsu_sb_pipe_vld & lsu_sb_wen;

    // x0 is never tracked: it always reads as zero pending writes.
    assign eff_arr[0]      = '0;
    assign cnt_next_arr[0] = '0;
    assign uf_vec[0]       = 1'b0;

    for (genvar r = 1; r < RF_DEPTH; r++) begin : g_cnt
        logic [1:0] dec_r;
        logic [1:0] inc_r;

        assign dec_r = count2(wb_hit[0] && (lsu_sb_rd[0] == RF_DEPTH_BIT'(r)),
                              wb_hit[1] && (lsu_sb_rd[1] == RF_DEPTH_BIT'(r)));
        assign inc_r = count2(fire[0] && slot[0].rd_wen && (slot[0].rd == RF_DEPTH_BIT'(r)),
                              fire[1] && slot[1].rd_wen && (slot[1].rd == RF_DEPTH_BIT'(r)));

        u_rf_sb_cnt u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .inc       (inc_r),
            .dec       (dec_r),
            .eff       (eff_arr[r]),
            .cnt_next  (cnt_next_arr[r]),
            .underflow (uf_vec[r])
        );
    end

    always_comb begin
        for (int r = 0; r < RF_DEPTH; r++) begin
            busy_vec[r] = |cnt_next_arr[r];
        end
    end

    // Issue decision. eff already includes this cycle's writebacks, so a
    // source whose last write completes now is ready via the RF bypass.
    logic                rdy0, rdy1, sat0, sat1, raw1, waw;
    logic [SB_CNT_W:0]   need1;

    always_comb begin
        rdy0 = (!slot[0].rs1_use || (eff_arr[slot[0].rs1_idx] == '0)) &&
               (!slot[0].rs2_use || (eff_arr[slot[0].rs2_idx] == '0));
        rdy1 = (!slot[1].rs1_use || (eff_arr[slot[1].rs1_idx] == '0)) &&
               (!slot[1].rs2_use || (eff_arr[slot[1].rs2_idx] == '0));

        // Room for one more pending write on rd0.
        sat0 = !slot[0].rd_wen || (eff_arr[slot[0].rd] != SB_CNT_MAX);

        // Slot 1 reading what slot 0 writes in the same bundle.
        raw1 = slot[0].rd_wen && (slot[0].rd != '0) &&
               ((slot[1].rs1_use && (slot[1].rs1_idx == slot[0].rd)) ||
                (slot[1].rs2_use && (slot[1].rs2_idx == slot[0].rd)));

        // When both slots write the same rd, slot 1 must leave room for slot 0's increment too.
        waw   = slot[0].rd_wen && slot[1].rd_wen && (slot[0].rd == slot[1].rd);
        need1 = {1'b0, eff_arr[slot[1].rd]} + (SB_CNT_W+1)'(waw) + (SB_CNT_W+1)'(1);
        sat1  = !slot[1].rd_wen || (need1 <= {1'b0, SB_CNT_MAX});

        issue_ok[0] = !flush && rdy0 && sat0;
        issue_ok[1] = !flush && slot[0].vld && issue_ok[0] && rdy1 && !raw1 && sat1;

        for (int i = 0; i < SUPER_SCALAR_NUM; i++) begin
            fire[i] = slot[i].vld && issue_ok[i];
        end
    end

    assign sb_idu_issue_ok = issue_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_busy_any  <= 1'b0;
            sb_err       <= 1'b0;
            sb_stall_cnt <= '0;
        end else begin
            sb_busy_any <= |busy_vec;
            if (|uf_vec) begin
                sb_err <= 1'b1;
            end
            if (!flush && slot[0].vld && !issue_ok[0]) begin
                sb_stall_cnt <= sb_stall_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: doc/u_rf_scoreboard.md
Name: u_rf_scoreboard

Overview:
- Issue-side hazard controller for the 2-write/2-read-port integer register file.
- Keeps a per-register pending-write counter. Tells the IDU each cycle which of its two in-order issue slots may issue without a RAW hazard or counter overflow.
- Counters increment on issue and decrement on LSU writeback.
- Sources whose last pending write completes in the current cycle count as ready, because the RF bypass path supplies that data.

Parameters:
- SUPER_SCALAR_NUM, 2, issue/writeback slots (global define).
- RF_DEPTH, 32, architectural registers (global define).
- RF_DEPTH_BIT, 5, register index width (global define).
- SB_CNT_W, 2, pending counter width; SB_CNT_MAX = 2^SB_CNT_W-1.
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; clears all pending state
- idu_sb_vld[2]  in  1  slot i holds a decoded instruction
- idu_sb_rs1_idx[2]  in  RF_DEPTH_BIT  source 1 index
- idu_sb_rs2_idx[2]  in  RF_DEPTH_BIT  source 2 index
- idu_sb_rs1_use[2]  in  1  source 1 is read
- idu_sb_rs2_use[2]  in  1  source 2 is read
- idu_sb_rd_wen[2]  in  1  slot writes rd (always 0 when rd==0)
- idu_sb_rd[2]  in  RF_DEPTH_BIT  destination index
- lsu_sb_pipe_vld[2]  in  1  writeback slot valid
- lsu_sb_wen[2]  in  1  writeback writes rd
- lsu_sb_rd[2]  in  RF_DEPTH_BIT  writeback destination
- sb_idu_issue_ok[2]  out  1  slot i may issue this cycle (combinational)
- sb_busy_any  out  1  some register has a pending write (registered)
- sb_err  out  1  sticky underflow/protocol error
- sb_stall_cnt  out  PERF_W  cycles with idu_sb_vld[0]=1 and issue_ok[0]=0

Behaviour:
- Reset values: all counters 0, sb_busy_any 0, sb_err 0, sb_stall_cnt 0. Async assertion mid-operation clears everything immediately.
- x0 is never tracked. Its counter is hard 0 and a source index of 0 is always ready.
- dec[r] = number of slots j (0..2) with lsu_sb_pipe_vld[j] & lsu_sb_wen[j] & lsu_sb_rd[j]==r.
- eff[r] = cnt[r] - dec[r]. A source is ready iff its use bit is 0 or eff[idx]==0.
- Issue rule, slot 0: issue_ok[0] = !flush & rs1 ready & rs2 ready & (!rd_wen[0] | eff[rd0] + 1 <= SB_CNT_MAX).
- Issue rule, slot 1 (in-order): issue_ok[1] = !flush & vld[0] & issue_ok[0] & its sources ready & its saturation check passes.
- Slot 1 intra-bundle RAW: if rd_wen[0] and rd0 equals a used nonzero slot-1 source, slot 1 is blocked.
- Slot 1 saturation check counts slot 0's increment when both slots target the same rd (WAW).
- issue_ok is independent of the slot's own vld. Fire[i] = vld[i] & issue_ok[i].
- Counter update: cnt_next[r] = eff[r] + number of fired slots with rd_wen & rd==r.
- Underflow: a decrement with cnt-dec < 0 holds the counter at 0 and sets sb_err (sticky until reset).
- Flush: in the flush cycle, issue_ok is forced 0. That cycle's writebacks are ignored and every counter is 0 next cycle.
- Flush contract: killed instructions never write back after a flush.
- sb_busy_any is the registered OR of cnt_next over all registers, so it is valid one cycle after each update.
- sb_stall_cnt increments by 1 in each stall cycle and wraps modulo 2^PERF_W. It does not count during flush.
- Latency: issue decision is same-cycle combinational. State update takes effect on the next clk edge.

Decomposition:
- Shared package: SB_CNT_W, SB_CNT_MAX, PERF_W, and a struct for an issue slot (vld, rs1/rs2 idx+use, rd_wen, rd).
- The existing global defines are reused.
- Sub-module u_rf_sb_cnt: one per register 1..31.
  - Inputs: inc (0..2), dec (0..2), flush.
  - Outputs: eff, a saturating counter, and an underflow pulse.
- The top level holds the match decoders, issue logic and perf counter.

Test Plan:
- Reset then idle: slot0 vld, rs1=5 used, cnt all 0 -> issue_ok=2'b11, sb_busy_any=0, sb_err=0.
- Issue slot0 rd=5, next cycle slot0 reads rs1=5 -> issue_ok[0]=0 and sb_stall_cnt=1. Then LSU wb rd=5 in the same cycle -> issue_ok[0]=1 (bypass) and cnt[5]=0 next cycle.
- Bundle: slot0 rd=7, slot1 rs2=7 used -> issue_ok=2'b01. Slot1 rs2=7 with rs2_use=0 -> 2'b11.
- WAW saturation, SB_CNT_W=2: cnt[9]=2, both slots rd=9 -> ok[0]=1, ok[1]=0, cnt[9]=3. A further issue to rd 9 is blocked until a wb arrives.
- Dual wb both rd=3 with cnt[3]=1 -> cnt[3]=0 and sb_err=1, which stays 1 until rst_n.
- cnt[4]=2, flush with a simultaneous wb rd=4 -> issue_ok=0 that cycle, all counters 0 and sb_busy_any=0 next cycle. Assert rst_n low mid-stream -> all outputs 0 immediately.
